// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit and its return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JREG   = 2'b10,
    PC_RET    = 2'b11
  } pcsrc_t;

  localparam int unsigned INC_DEFAULT = 4;

  // Instruction fetch targets must be word aligned.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control-side bundle of the PC unit: next-PC selection inputs and fetch/RAS status outputs.
interface pc_unit_if #(
  parameter int ADDRESS_WIDTH = 32
);
  import pc_pkg::*;

  logic                     stall;
  pcsrc_t                   PCsrc;
  logic [ADDRESS_WIDTH-1:0] ImmOp;
  logic [ADDRESS_WIDTH-1:0] RegTarget;
  logic                     call;
  logic [ADDRESS_WIDTH-1:0] PC;
  logic                     ras_empty;
  logic                     ras_full;
  logic                     misalign;

  modport master (
    output stall, PCsrc, ImmOp, RegTarget, call,
    input  PC, ras_empty, ras_full, misalign
  );

  modport slave (
    input  stall, PCsrc, ImmOp, RegTarget, call,
    output PC, ras_empty, ras_full, misalign
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wdata,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;       // next free slot; top lives one below
  logic [PW-1:0] top_idx;
  logic [CW-1:0] count;
  logic          do_pop;

  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && do_pop) begin
      // Return-and-call: top is replaced in place, depth unchanged.
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (do_pop) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // NOTE: the storage array has no reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[do_pop ? top_idx : ptr] <= wdata;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: next-PC selection, alignment check, stall and return-address prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned            INC           = INC_DEFAULT,
  parameter int                     RAS_DEPTH     = 4
) (
  input logic      clk,
  input logic      rst,
  pc_unit_if.slave bus
);

  localparam int AW = ADDRESS_WIDTH;

  logic [AW-1:0] pc_q;
  logic          misalign_q;
  logic [AW-1:0] seq_pc;
  logic [AW-1:0] candidate;
  logic [AW-1:0] ras_top;
  logic          ras_empty;
  logic          ras_full;
  logic          want_pop;
  logic          advance;

  assign seq_pc = pc_q + AW'(INC);

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    candidate = seq_pc;
    want_pop  = 1'b0;
    unique case (bus.PCsrc)
      PC_INC:    candidate = seq_pc;
      PC_BRANCH: candidate = pc_q + bus.ImmOp;
      PC_JREG:   candidate = bus.RegTarget & ~AW'(1);
      PC_RET: begin
        if (!ras_empty) begin
          candidate = ras_top;
          want_pop  = 1'b1;
        end
      end
      default:   candidate = seq_pc;
    endcase
  end

  assign advance = rst && !bus.stall && is_aligned(candidate[1:0]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else if (bus.stall) begin
      misalign_q <= 1'b0;
    end else if (!is_aligned(candidate[1:0])) begin
      misalign_q <= 1'b1;
    end else begin
      pc_q       <= candidate;
      misalign_q <= 1'b0;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .AW    (AW)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.call && advance),
    .pop   (want_pop && advance),
    .wdata (seq_pc),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign bus.PC        = pc_q;
  assign bus.misalign  = misalign_q;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;

endmodule
